aes_enc_iter: RTL and testbench



---
 rtl/aes_enc_iter_pkg.sv | 55 +++++
 rtl/aes_enc_iter_sbox.sv | 17 +
 rtl/aes_enc_iter.sv | 179 +++++++++++++++++
 tb/tb_aes_enc_iter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_enc_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_enc_iter_pkg
// Purpose : Shared AES constants, FSM state type, S-box table and GF(2^8)
//           helpers used by the iterative encryption core.
// Revision: 1.0 - initial release
// ============================================================================
package aes_enc_iter_pkg;

  localparam int AES_DATA_W    = 128;
  localparam int AES_KEY_L_DEF = 128;
  localparam int NR_128        = 10;
  localparam int NR_256        = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are MSB-first: c[31:24] is row 0.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_iter_sbox.sv
`default_nettype none
// ============================================================================
// Module  : aes_sbox
// Purpose : 8-bit combinational AES forward S-box lookup.
// Revision: 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_enc_iter_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = SBOX[a_i];

endmodule
`default_nettype wire

// File: rtl/aes_enc_iter.sv
`default_nettype none
// ============================================================================
// Module  : aes_enc_iter
// Purpose : Iterative AES-128/256 encryption core, one round per clock with
//           on-the-fly key expansion and valid/ready handshakes both sides.
//           Define AES_BLK_CNT_EN to add the blk_cnt completed-block counter.
// Revision: 1.0 - initial release
// ============================================================================
module aes_enc_iter
  import aes_enc_iter_pkg::*;
#(
  parameter int KEY_L  = AES_KEY_L_DEF,
  parameter int DATA_W = AES_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [KEY_L-1:0]  cipher_key,
  input  logic [DATA_W-1:0] plain_text,
  output logic [DATA_W-1:0] cipher_text,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              busy
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  localparam int         NR   = (KEY_L == 256) ? NR_256 : NR_128;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_L != 128 && KEY_L != 256) begin : g_bad_key_l
    $fatal(1, "aes_enc_iter: KEY_L must be 128 or 256");
  end
  if (DATA_W != AES_DATA_W) begin : g_bad_data_w
    $fatal(1, "aes_enc_iter: DATA_W must be 128");
  end

  state_e             state_q, state_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [127:0]       st_q, st_d;
  logic [KEY_L-1:0]   win_q, win_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [DATA_W-1:0]  ct_q, ct_d;

  logic [7:0]         w_sb [16];
  logic [127:0]       w_sr, w_mc, w_rk, w_round, w_head;
  logic [31:0]        w_subw, w_rotw, w_t, w_k0, w_k1, w_k2, w_k3;
  logic [127:0]       w_newkey;
  logic [KEY_L-1:0]   w_win_nxt;
  logic               w_rcon_adv;

  // Round datapath: SubBytes -> ShiftRows -> MixColumns; state bytes MSB-first, column-major.
  for (genvar b = 0; b < 16; b++) begin : g_subbytes
    aes_sbox u_sbox (.a_i(st_q[127-8*b -: 8]), .y_o(w_sb[b]));
  end

  for (genvar b = 0; b < 16; b++) begin : g_shiftrows
    localparam int ROW = b % 4;
    localparam int COL = b / 4;
    assign w_sr[127-8*b -: 8] = w_sb[4*((COL+ROW)%4)+ROW];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mixcol
    assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
  end

  assign w_round = ((rnd_q == NR_L) ? w_sr : w_mc) ^ w_rk;

  // Key schedule: the youngest window word feeds SubWord; RotWord commutes with it.
  for (genvar j = 0; j < 4; j++) begin : g_subword
    aes_sbox u_sbox (.a_i(win_q[8*j+7 -: 8]), .y_o(w_subw[8*j+7 -: 8]));
  end

  assign w_rotw   = {w_subw[23:0], w_subw[31:24]} ^ {rcon_q, 24'h000000};
  assign w_k0     = w_head[127:96] ^ w_t;
  assign w_k1     = w_head[95:64]  ^ w_k0;
  assign w_k2     = w_head[63:32]  ^ w_k1;
  assign w_k3     = w_head[31:0]   ^ w_k2;
  assign w_newkey = {w_k0, w_k1, w_k2, w_k3};

  if (KEY_L == 256) begin : g_ks256
    // Round 1 reuses the key's second half; afterwards even rounds take the Rcon step.
    assign w_head = win_q[255:128];
    assign w_t    = rnd_q[0] ? w_subw : w_rotw;
    always_comb begin
      w_rk       = w_newkey;
      w_win_nxt  = {win_q[127:0], w_newkey};
      w_rcon_adv = ~rnd_q[0];
      if (rnd_q == 4'd1) begin
        w_rk       = win_q[127:0];
        w_win_nxt  = win_q;
        w_rcon_adv = 1'b0;
      end
    end
  end else begin : g_ks128
    assign w_head     = win_q[127:0];
    assign w_t        = w_rotw;
    assign w_rk       = w_newkey;
    assign w_win_nxt  = w_newkey;
    assign w_rcon_adv = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    win_d   = win_q;
    rcon_d  = rcon_q;
    ct_d    = ct_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          win_d   = cipher_key;
          rcon_d  = 8'h01;
          st_d    = plain_text ^ cipher_key[KEY_L-1 -: 128];
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d  = w_round;
        win_d = w_win_nxt;
        rnd_d = rnd_q + 4'd1;
        if (w_rcon_adv) rcon_d = xtime(rcon_q);
        if (rnd_q == NR_L) begin
          ct_d    = w_round;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      win_q   <= '0;
      rcon_q  <= 8'h01;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      win_q   <= win_d;
      rcon_q  <= rcon_d;
      ct_q    <= ct_d;
    end
  end

  assign ready_in    = (state_q == IDLE) && !reset;
  assign valid_out   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign cipher_text = ct_q;

`ifdef AES_BLK_CNT_EN
  logic [31:0] blk_cnt_q;

  // A reset that lands on an in-flight block only aborts it; a reset seen while idle clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == IDLE) blk_cnt_q <= '0;
    end else if (valid_out && ready_out) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_enc_iter
// Purpose : Self-checking bench for aes_enc_iter (AES-128 and AES-256 cores)
//           with a queue scoreboard fed by an independent AES model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_enc_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         vin128, ri128, vo128, ro128, busy128;
  logic [127:0] key128, pt128, ct128;
  logic         vin256, ri256, vo256, ro256, busy256;
  logic [255:0] key256;
  logic [127:0] pt256, ct256;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  cnt128, cnt256;
`endif

  aes_enc_iter #(.KEY_L(128), .DATA_W(128)) u_dut128 (
    .clk(clk), .reset(reset), .valid_in(vin128), .ready_in(ri128),
    .cipher_key(key128), .plain_text(pt128), .cipher_text(ct128),
    .valid_out(vo128), .ready_out(ro128), .busy(busy128)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(cnt128)
`endif
  );

  aes_enc_iter #(.KEY_L(256), .DATA_W(128)) u_dut256 (
    .clk(clk), .reset(reset), .valid_in(vin256), .ready_in(ri256),
    .cipher_key(key256), .plain_text(pt256), .cipher_text(ct256),
    .valid_out(vo256), .ready_out(ro256), .busy(busy256)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(cnt256)
`endif
  );

  int           checks = 0;
  int           errors = 0;
  int           cnt_exp128 = 0;
  logic [127:0] sb128 [$];
  logic [127:0] sb256 [$];
  logic [7:0]   tb_sbox [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a != 8'h00) begin
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, a);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
  endfunction

  // nk = 4 uses key[127:0]; nk = 8 uses the whole 256-bit key.
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*nk-1-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) t[b] = tb_sbox[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r+b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // One block through the selected core; hold > 0 stalls ready_out for that many cycles in DONE.
  task automatic do_block(input bit s, input logic [255:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input int hold, input string tag);
    int           n;
    logic [127:0] want;
    @(negedge clk);
    if (s) begin key256 = key;        pt256 = pt; vin256 = 1'b1; ro256 = (hold == 0); end
    else   begin key128 = key[127:0]; pt128 = pt; vin128 = 1'b1; ro128 = (hold == 0); end
    chk({tag, " ready_in idle"}, 128'(s ? ri256 : ri128), 128'd1);
    @(posedge clk);
    if (s) sb256.push_back(exp); else sb128.push_back(exp);
    @(negedge clk);
    vin128 = 1'b0;
    vin256 = 1'b0;
    n = 0;
    while (!(s ? vo256 : vo128) && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 128'(n), s ? 128'd14 : 128'd10);
    want = s ? sb256.pop_front() : sb128.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, " hold valid_out"}, 128'(s ? vo256 : vo128), 128'd1);
      chk({tag, " hold cipher_text"}, s ? ct256 : ct128, want);
      chk({tag, " hold ready_in"}, 128'(s ? ri256 : ri128), 128'd0);
      if (s) begin vin256 = 1'b1; pt256 = ~pt; end
      else   begin vin128 = 1'b1; pt128 = ~pt; end
      @(negedge clk);
    end
    vin128 = 1'b0;
    vin256 = 1'b0;
    chk({tag, " cipher_text"}, s ? ct256 : ct128, want);
    if (s) ro256 = 1'b1; else ro128 = 1'b1;
    @(posedge clk);
    if (!s) cnt_exp128++;
    @(negedge clk);
    chk({tag, " valid_out drop"}, 128'(s ? vo256 : vo128), 128'd0);
    chk({tag, " busy/ready_in idle"}, 128'(s ? {busy256, ri256} : {busy128, ri128}), 128'd1);
    chk({tag, " cipher_text retained"}, s ? ct256 : ct128, want);
  endtask

  initial begin
    logic [255:0] rk;
    logic [127:0] rp;
    for (int a = 0; a < 256; a++) tb_sbox[a] = ref_sbox(8'(a));

    reset  = 1'b1;
    vin128 = 1'b0; ro128 = 1'b1; key128 = '0; pt128 = '0;
    vin256 = 1'b0; ro256 = 1'b1; key256 = '0; pt256 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready_in", 128'(ri128), 128'd0);
    chk("reset valid_out", 128'(vo128), 128'd0);
    chk("reset cipher_text", ct128, 128'd0);
    chk("reset busy", 128'(busy128), 128'd0);
    chk("reset cipher_text 256", ct256, 128'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset ready_in", 128'(ri128), 128'd1);
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt reset", 128'(cnt128), 128'd0);
`endif

    do_block(1'b0, 256'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "aes128 vec1");
    do_block(1'b0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
             128'h3925841d02dc09fbdc118597196a0b32, 0, "aes128 vec2");
    do_block(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
             128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 0, "aes256 vec");

    rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rp = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_block(1'b0, rk, rp, aes_ref(rk, 4, rp), 20, "backpressure");

    // Abort: reset lands while the 128-bit core is on round 5.
    @(negedge clk);
    key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pt128  = 128'h3243f6a8885a308d313198a2e0370734;
    vin128 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin128 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort busy before", 128'(busy128), 128'd1);
    reset = 1'b1;
    chk("abort ready_in in reset", 128'(ri128), 128'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort valid_out", 128'(vo128), 128'd0);
    chk("abort cipher_text", ct128, 128'd0);
    chk("abort busy", 128'(busy128), 128'd0);
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt after abort", 128'(cnt128), 128'(cnt_exp128));
`endif
    do_block(1'b0, 256'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "after abort");

    for (int i = 0; i < 200; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i % 2 == 1) do_block(1'b1, rk, rp, aes_ref(rk, 8, rp), 0, "rand256");
      else            do_block(1'b0, rk, rp, aes_ref(rk, 4, rp), 0, "rand128");
    end
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt final", 128'(cnt128), 128'(cnt_exp128));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
